fp8_to_fixed: RTL and testbench

FP8_TO_FIXED -- requirements
Module: fp8_to_fixed

---
 rtl/fp8_to_fixed.sv | 142 ++++++++++++++
 tb/tb_fp8_to_fixed.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp8_to_fixed.sv
// Sequential fp8 (1-4-3, implicit leading one) to signed Q11.4 fixed-point converter.
// Optional macro FP8_TO_FIXED_ROUND_EN: round half away from zero instead of truncating.
module fp8_to_fixed #(
    parameter int BIAS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_inf,
    output logic        out_nan
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {K_NORMAL, K_ZERO, K_INF, K_NAN} kind_t;

    // The mantissa register already carries 3 fraction bits, so one extra left shift reaches 4.
    localparam logic signed [5:0] K_OFFSET = 6'(1 - BIAS);

`ifdef FP8_TO_FIXED_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    kind_t             kind;
    kind_t             kind_in;
    logic              sign;
    logic              shift_left;
    logic              guard;
    logic [3:0]        count;
    logic [15:0]       mag;
    logic [15:0]       mag_final;
    logic signed [5:0] k_in;
    logic [3:0]        k_abs;

    // Operand decode, evaluated combinationally and used only on the capture edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        kind_in = K_NORMAL;
        k_in    = $signed({2'b00, in_data[6:3]}) + K_OFFSET;
        k_abs   = 4'(k_in[5] ? -k_in : k_in);
        if (in_data[6:3] == 4'hF)
            kind_in = (in_data[2:0] == 3'd0) ? K_INF : K_NAN;
        else if (in_data[6:0] == 7'd0)
            kind_in = K_ZERO;
    end

    assign mag_final = mag + {15'd0, guard & ROUND_EN};

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)       state_next = SHIFT;
            SHIFT:   if (count == 4'd0)  state_next = DONE;
            DONE:    if (out_ready)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind       <= K_ZERO;
            sign       <= 1'b0;
            shift_left <= 1'b0;
            guard      <= 1'b0;
            count      <= 4'd0;
            mag        <= 16'd0;
            out_valid  <= 1'b0;
            out_data   <= 16'd0;
            out_inf    <= 1'b0;
            out_nan    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_data[7];
                        kind  <= kind_in;
                        guard <= 1'b0;
                        if (kind_in == K_NORMAL) begin
                            mag        <= {12'd0, 1'b1, in_data[2:0]};
                            count      <= k_abs;
                            shift_left <= ~k_in[5];
                        end else begin
                            mag        <= 16'd0;
                            count      <= 4'd0;
                            shift_left <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (count != 4'd0) begin
                        if (shift_left) begin
                            mag <= mag << 1;
                        end else begin
                            mag   <= mag >> 1;
                            guard <= mag[0];
                        end
                        count <= count - 4'd1;
                    end else begin
                        out_valid <= 1'b1;
                        out_inf   <= 1'b0;
                        out_nan   <= 1'b0;
                        case (kind)
                            K_NORMAL: out_data <= sign ? 16'(-mag_final) : mag_final;
                            K_INF: begin
                                out_data <= sign ? 16'h8000 : 16'h7FFF;
                                out_inf  <= 1'b1;
                            end
                            K_NAN: begin
                                out_data <= 16'd0;
                                out_nan  <= 1'b1;
                            end
                            default:  out_data <= 16'd0;
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_to_fixed.sv
// Directed, table-driven bench for fp8_to_fixed plus handshake and reset sequences.
module tb_fp8_to_fixed;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_inf;
    logic        out_nan;

    int total = 0;
    int bad   = 0;

`ifdef FP8_TO_FIXED_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [7:0]  din;
        logic [15:0] dout;
        logic        inf;
        logic        nan;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    fp8_to_fixed #(.BIAS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inf   (out_inf),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v.din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h55;
        wait_valid(tag, lat);
        check({tag, "_lat"},  32'(lat),      32'(v.lat));
        check({tag, "_data"}, 32'(out_data), 32'(v.dout));
        check({tag, "_inf"},  32'(out_inf),  32'(v.inf));
        check({tag, "_nan"},  32'(out_nan),  32'(v.nan));
        out_ready = 1'b1;
        #1;
        check({tag, "_no_bypass"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        vecs[0]  = '{8'h38, 16'h0010, 1'b0, 1'b0, 2};
        vecs[1]  = '{8'hF7, 16'hF100, 1'b0, 1'b0, 9};
        vecs[2]  = '{8'h1C, RND ? 16'h0002 : 16'h0001, 1'b0, 1'b0, 4};
        vecs[3]  = '{8'h78, 16'h7FFF, 1'b1, 1'b0, 1};
        vecs[4]  = '{8'hF8, 16'h8000, 1'b1, 1'b0, 1};
        vecs[5]  = '{8'h79, 16'h0000, 1'b0, 1'b1, 1};
        vecs[6]  = '{8'h80, 16'h0000, 1'b0, 1'b0, 1};
        vecs[7]  = '{8'h40, 16'h0020, 1'b0, 1'b0, 3};
        vecs[8]  = '{8'hB8, 16'hFFF0, 1'b0, 1'b0, 2};
        vecs[9]  = '{8'h2B, RND ? 16'h0006 : 16'h0005, 1'b0, 1'b0, 2};
        vecs[10] = '{8'hAB, RND ? 16'hFFFA : 16'hFFFB, 1'b0, 1'b0, 2};
        vecs[11] = '{8'h08, 16'h0000, 1'b0, 1'b0, 6};
        vecs[12] = '{8'h00, 16'h0000, 1'b0, 1'b0, 1};
        vecs[13] = '{8'hFF, 16'h0000, 1'b0, 1'b1, 1};
        vecs[14] = '{8'h70, 16'h0800, 1'b0, 1'b0, 9};
        vecs[15] = '{8'h3F, 16'h001E, 1'b0, 1'b0, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data",  32'(out_data),  32'd0);
        check("reset_flags", 32'({out_inf, out_nan}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i], $sformatf("vec%0d_%02h", i, vecs[i].din));

        // Backpressure with a stray operand held on the input the whole time.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h38;
        @(posedge clk); #1;
        in_data = 8'h78;
        wait_valid("bp", lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_data%0d", i),  32'(out_data),  32'h0010);
            check($sformatf("bp_hold_ready%0d", i), 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_handshake_valid", 32'(out_valid), 32'd0);
        check("bp_handshake_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        check("bp_no_capture_at_handshake", 32'(in_ready), 32'd1);

        // Leave non-zero held outputs, then reset in the middle of a long shift.
        run_vec(vecs[3], "pre_reset_inf");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_inf",   32'(out_inf),   32'd0);
        check("mid_rst_nan",   32'(out_nan),   32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        run_vec(vecs[0], "post_reset_38");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
